multicycle_alu: RTL



---
 rtl/alu_pkg.sv | 31 +++
 rtl/multicycle_alu_seq_divider.sv | 83 ++++++++
 rtl/multicycle_alu.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode map, FSM states, flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd5;
    localparam logic [3:0] OP_MOD = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;
    localparam logic [3:0] OP_SLL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int NUM_FLAGS  = 6;
    localparam int FLAG_ZR    = 5;
    localparam int FLAG_NEG   = 4;
    localparam int FLAG_CARRY = 3;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_DIVZ  = 1;
    localparam int FLAG_BAD   = 0;

endpackage

// File: rtl/multicycle_alu_seq_divider.sv
// Iterative signed divider: restoring division on magnitudes, DIV_UNROLL quotient bits
// per cycle. The sign-fixed result is presented combinationally during the final iteration.
module seq_divider #(
    parameter int WIDTH      = 32,
    parameter int DIV_UNROLL = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int N     = WIDTH / DIV_UNROLL;
    localparam int CNT_W = $clog2(N + 1);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs_mag;
    logic             q_neg, r_neg;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in;

    // Magnitude of the MIN operand wraps to 2^(WIDTH-1), which is correct read as unsigned.
    assign dvd_mag_in = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag_in = divisor[WIDTH-1]  ? -divisor  : divisor;

    // DIV_UNROLL restoring steps: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        rem_nxt = rem;
        quo_nxt = quo;
        rem_sh  = '0;
        for (int i = 0; i < DIV_UNROLL; i++) begin
            rem_sh  = {rem_nxt, quo_nxt[WIDTH-1]};
            quo_nxt = {quo_nxt[WIDTH-2:0], 1'b0};
            if (rem_sh >= {1'b0, dvs_mag}) begin
                rem_nxt    = rem_sh[WIDTH-1:0] - dvs_mag;
                quo_nxt[0] = 1'b1;
            end else begin
                rem_nxt = rem_sh[WIDTH-1:0];
            end
        end
    end

    assign done      = busy && (cnt == CNT_W'(1));
    assign quotient  = q_neg ? -quo_nxt : quo_nxt;
    assign remainder = r_neg ? -rem_nxt : rem_nxt;

    // Iteration counter; reset abandons any division in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(N);
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    // Working registers: load magnitudes and result signs on start, then iterate.
    always_ff @(posedge clock) begin
        if (start) begin
            rem     <= '0;
            quo     <= dvd_mag_in;
            dvs_mag <= dvs_mag_in;
            q_neg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg   <= dividend[WIDTH-1];
        end else if (busy) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU with valid/ready handshakes: single-cycle ops register at accept,
// DIV/MOD by a nonzero divisor run on the iterative divider.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIV_UNROLL = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       controlBits,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             divZero,
    output logic             badOp
);

    localparam int SH_W = $clog2(WIDTH);

    state_t                   state, state_nxt;
    logic                     ready_en;
    logic                     is_div, start_div, load_alu, load_div;
    logic signed [WIDTH-1:0]  op_a, op_b;
    logic [WIDTH:0]           sum_ext, diff_ext;
    logic signed [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]         alu_res;
    logic                     alu_carry, alu_ovf, alu_divz, alu_bad;
    logic                     div_done, div_is_mod, div_ovf;
    logic [WIDTH-1:0]         div_quo, div_rem, div_res;
    logic [NUM_FLAGS-1:0]     flags;

    function automatic logic [NUM_FLAGS-1:0] make_flags(input logic [WIDTH-1:0] res,
                                                        input logic c, input logic v,
                                                        input logic dz, input logic bo);
        logic [NUM_FLAGS-1:0] f;
        f             = '0;
        f[FLAG_ZR]    = (res == '0);
        f[FLAG_NEG]   = res[WIDTH-1];
        f[FLAG_CARRY] = c;
        f[FLAG_OVF]   = v;
        f[FLAG_DIVZ]  = dz;
        f[FLAG_BAD]   = bo;
        return f;
    endfunction

    assign op_a    = $signed(in1);
    assign op_b    = $signed(in2);
    assign is_div  = ((controlBits == OP_DIV) || (controlBits == OP_MOD)) && (in2 != '0);
    assign div_res = div_is_mod ? div_rem : div_quo;

    // Single-cycle result and flags; DIV/MOD here only covers the divide-by-zero case.
    always_comb begin
        sum_ext   = {1'b0, in1} + {1'b0, in2};
        diff_ext  = {1'b0, in1} - {1'b0, in2};
        product   = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_divz  = 1'b0;
        alu_bad   = 1'b0;
        case (controlBits)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_ext[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = ~diff_ext[WIDTH];
                alu_ovf   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff_ext[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_XOR: alu_res = in1 ^ in2;
            OP_MUL: begin
                alu_res = product[WIDTH-1:0];
                alu_ovf = product[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){product[WIDTH-1]}};
            end
            OP_DIV: begin
                alu_res  = '1;
                alu_divz = 1'b1;
            end
            OP_MOD: begin
                alu_res  = in1;
                alu_divz = 1'b1;
            end
            OP_OR:  alu_res = in1 | in2;
            OP_AND: alu_res = in1 & in2;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            OP_SLL: alu_res = in1 << in2[SH_W-1:0];
            OP_SRA: alu_res = op_a >>> in2[SH_W-1:0];
            default: alu_bad = 1'b1;
        endcase
    end

    // Next state, handshake and load strobes; a take in DONE may accept a new op in the same cycle.
    always_comb begin
        state_nxt = state;
        inReady   = 1'b0;
        start_div = 1'b0;
        load_alu  = 1'b0;
        load_div  = 1'b0;
        case (state)
            IDLE: inReady = ready_en;
            DIV_RUN: begin
                if (div_done) begin
                    load_div  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (outReady) begin
                    inReady   = ready_en;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (inReady && inValid) begin
            if (is_div) begin
                start_div = 1'b1;
                state_nxt = DIV_RUN;
            end else begin
                load_alu  = 1'b1;
                state_nxt = DONE;
            end
        end
    end

    // State register; ready_en keeps inReady low while reset is asserted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
        end
    end

    // Per-division context needed when the quotient/remainder comes back.
    always_ff @(posedge clock) begin
        if (start_div) begin
            div_is_mod <= (controlBits == OP_MOD);
            div_ovf    <= (controlBits == OP_DIV) && (in1 == {1'b1, {(WIDTH-1){1'b0}}}) && (in2 == '1);
        end
    end

    // Output register: holds result and flags until the consumer takes them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outValid <= 1'b0;
            out      <= '0;
            flags    <= '0;
        end else if (load_alu) begin
            outValid <= 1'b1;
            out      <= alu_res;
            flags    <= make_flags(alu_res, alu_carry, alu_ovf, alu_divz, alu_bad);
        end else if (load_div) begin
            outValid <= 1'b1;
            out      <= div_res;
            flags    <= make_flags(div_res, 1'b0, div_ovf, 1'b0, 1'b0);
        end else if (outValid && outReady) begin
            outValid <= 1'b0;
        end
    end

    assign zr      = flags[FLAG_ZR];
    assign neg     = flags[FLAG_NEG];
    assign carry   = flags[FLAG_CARRY];
    assign ovf     = flags[FLAG_OVF];
    assign divZero = flags[FLAG_DIVZ];
    assign badOp   = flags[FLAG_BAD];

    seq_divider #(
        .WIDTH      (WIDTH),
        .DIV_UNROLL (DIV_UNROLL)
    ) u_div (
        .clock     (clock),
        .reset     (reset),
        .start     (start_div),
        .dividend  (in1),
        .divisor   (in2),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

endmodule
